// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter in front of one async FIFO write port.
// One requester at a time owns the port from its first beat to its last
// beat (or until the length watchdog forces a release). All requesters and
// the FIFO write side share the clk_wr domain.
//
// Handshake: a beat moves from requester i to the FIFO on a rising clk_wr
// edge where req_valid[i] && req_ready[i]. req_ready is only ever offered to
// the current owner and only while fifo_full is low, so fifo_wr_en is exactly
// that transfer condition and never rises against a full FIFO. A requester
// must hold its data/last stable while valid is high and ready is low.
module fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                                          clk_wr,
  input  logic                                          rst_n,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                 req_data,
  input  logic [NUM_REQ-1:0]                            req_last,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [DATA_WIDTH-1:0]                         fifo_wr_data,
  output logic                                          fifo_wr_en,
  input  logic                                          fifo_full,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                          busy,
  output logic                                          pkt_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_grant_id;
  logic [GW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_beat_cnt;
  logic                r_pkt_err;

  logic                w_any_req;
  logic                w_found;
  logic [GW-1:0]       w_sel;
  logic                w_g_valid;
  logic                w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                w_xfer;
  logic [CW-1:0]       w_cnt_inc;
  logic                w_end_last;
  logic                w_end_force;

  assign w_any_req   = |req_valid;
  assign w_xfer      = (r_state == ST_BUSY) && w_g_valid && !fifo_full;
  assign w_cnt_inc   = r_beat_cnt + CW'(1);
  assign w_end_last  = w_xfer && w_g_last;
  assign w_end_force = w_xfer && !w_g_last && (w_cnt_inc == CW'(MAX_PKT_LEN));

  // Round-robin search: first valid requester after the last one served, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_sel   = GW'(idx);
      end
    end
  end

  // Select the owner's valid/last/data lanes.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_g_valid = req_valid[i];
        w_g_last  = req_last[i];
        w_g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: one arbitration cycle in IDLE, hold BUSY until last beat or watchdog.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_end_last || w_end_force) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    busy         = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (r_state == ST_BUSY) begin
      busy         = 1'b1;
      fifo_wr_en   = w_g_valid && !fifo_full;
      fifo_wr_data = w_g_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (r_grant_id == GW'(i)) && !fifo_full;
      end
    end
  end

  // Grant, round-robin pointer, beat counter and watchdog pulse.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_id <= '0;
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_pkt_err <= w_end_force;
      if (r_state == ST_IDLE && w_any_req) begin
        r_grant_id <= w_sel;
        r_rr_ptr   <= w_sel;
      end
      if (w_end_last || w_end_force) begin
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= w_cnt_inc;
      end
    end
  end

  assign grant_id = r_grant_id;
  assign pkt_err  = r_pkt_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Each requester is fed from a beat
// list; every beat that should reach the FIFO is also pushed, in the order
// it must appear, onto exp_q as {grant_id, data}. Every FIFO write pops and
// compares one entry, so packet order, atomicity and data all get checked.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXL = 16;
  localparam int GW   = 2;
  localparam int EW   = GW + DW;

  logic               clk_wr = 1'b0;
  logic               rst_n  = 1'b0;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_last;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      fifo_wr_data;
  logic               fifo_wr_en;
  logic               fifo_full;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               pkt_err;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_PKT_LEN(MAXL)
  ) dut (
    .clk_wr      (clk_wr),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_err     (pkt_err)
  );

  // Clock and reset
  always #5 clk_wr = ~clk_wr;

  int              checks    = 0;
  int              failures  = 0;
  logic [EW-1:0]   exp_q[$];
  logic [DW:0]     src_mem[NR][64];
  int              src_hd[NR];
  int              src_tl[NR];
  logic [NR-1:0]   hold;
  logic            full_in;
  int              wr_cnt;
  int              err_cnt;
  int              err_at_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (src_hd[i] != src_tl[i]) e = 1'b0;
    return e;
  endfunction

  // Driver: present the head beat of every non-held requester list.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_hd[i] < src_tl[i] && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src_mem[i][src_hd[i]][DW-1:0];
        req_last[i]           = src_mem[i][src_hd[i]][DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
    fifo_full = full_in;
    #1;
  endtask

  task automatic add_beats(input int id, input int n, input logic [DW-1:0] base,
                           input bit last_end, input bit do_exp);
    logic [DW-1:0] d;
    logic          l;
    logic [GW-1:0] g;
    for (int b = 0; b < n; b++) begin
      d = base + DW'(b);
      l = last_end && (b == n - 1);
      g = GW'(id);
      src_mem[id][src_tl[id]] = {l, d};
      src_tl[id]++;
      if (do_exp) exp_q.push_back({g, d});
    end
  endtask

  // One clock: sample outputs mid-low-phase, score writes, advance beat lists.
  task automatic tick();
    logic [NR-1:0] xfer;
    logic [EW-1:0] e;
    if (fifo_full) check("no_wr_when_full", fifo_wr_en, 0);
    if (fifo_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL wr_unexpected: observed=0x%0h expected=none", {grant_id, fifo_wr_data});
      end else begin
        e = exp_q.pop_front();
        check("fifo_beat", {grant_id, fifo_wr_data}, e);
      end
    end
    if (pkt_err) begin
      err_cnt++;
      err_at_wr = wr_cnt;
    end
    xfer = req_valid & req_ready;
    @(posedge clk_wr);
    @(negedge clk_wr);
    for (int i = 0; i < NR; i++) if (xfer[i]) src_hd[i]++;
    drive();
  endtask

  task automatic drain(input string tag, input int budget, output int n);
    n = 0;
    while (n < budget && !(src_empty() && !busy && exp_q.size() == 0)) begin
      tick();
      n++;
    end
    check(tag, (n < budget), 1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    full_in = 1'b0;
    hold    = '0;
    for (int i = 0; i < NR; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk_wr);
    @(negedge clk_wr);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    wr_cnt    = 0;
    err_cnt   = 0;
    err_at_wr = -1;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);

    // Single requester 1, three beats: one IDLE cycle then three back-to-back writes
    wr_cnt = 0;
    add_beats(1, 3, 8'hA1, 1'b1, 1'b1);
    drive();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_wr_en", fifo_wr_en, 0);
    tick();
    check("t1_grant", grant_id, 1);
    check("t1_wr_en_b1", fifo_wr_en, 1);
    check("t1_ready", req_ready, 4'b0010);
    tick();
    check("t1_wr_en_b2", fifo_wr_en, 1);
    tick();
    check("t1_wr_en_b3", fifo_wr_en, 1);
    tick();
    check("t1_busy_fall", busy, 0);
    check("t1_wr_en_off", fifo_wr_en, 0);
    check("t1_wr_data_idle", fifo_wr_data, 0);
    check("t1_writes", wr_cnt, 3);

    // All four requesters from reset: order 0,1,2,3,0, each packet contiguous
    do_reset();
    wr_cnt = 0;
    add_beats(0, 2, 8'h00, 1'b1, 1'b1);
    add_beats(1, 2, 8'h10, 1'b1, 1'b1);
    add_beats(2, 2, 8'h20, 1'b1, 1'b1);
    add_beats(3, 2, 8'h30, 1'b1, 1'b1);
    add_beats(0, 2, 8'h02, 1'b1, 1'b1);
    drive();
    drain("t2_drain", 100, n);
    check("t2_writes", wr_cnt, 10);
    check("t2_cycles", n, 15);

    // FIFO full for 5 cycles after requester 2's first beat
    wr_cnt = 0;
    add_beats(2, 4, 8'hC0, 1'b1, 1'b1);
    drive();
    tick();
    tick();
    full_in = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      check("t3_full_wr_en", fifo_wr_en, 0);
      check("t3_full_ready", req_ready, 0);
      check("t3_full_grant", grant_id, 2);
      check("t3_full_busy", busy, 1);
      tick();
    end
    full_in = 1'b0;
    drive();
    drain("t3_drain", 50, n);
    check("t3_writes", wr_cnt, 4);
    check("t3_resume_cycles", n, 3);

    // Watchdog: requester 0 overruns MAX_PKT_LEN while requester 1 waits
    wr_cnt    = 0;
    err_cnt   = 0;
    err_at_wr = -1;
    add_beats(0, MAXL, 8'h40, 1'b0, 1'b1);
    add_beats(1, 2, 8'h90, 1'b1, 1'b1);
    add_beats(0, 4, 8'h50, 1'b1, 1'b1);
    drive();
    drain("t4_drain", 200, n);
    check("t4_err_count", err_cnt, 1);
    check("t4_err_after_beat", err_at_wr, MAXL);
    check("t4_writes", wr_cnt, MAXL + 6);

    // Requester 3 idles mid-packet; requester 0 must wait for its last beat
    wr_cnt = 0;
    add_beats(3, 4, 8'hD0, 1'b1, 1'b1);
    add_beats(0, 2, 8'hE0, 1'b1, 1'b1);
    drive();
    tick();
    tick();
    tick();
    hold[3] = 1'b1;
    drive();
    for (int k = 0; k < 4; k++) begin
      check("t5_gap_wr_en", fifo_wr_en, 0);
      check("t5_gap_grant", grant_id, 3);
      check("t5_gap_busy", busy, 1);
      tick();
    end
    hold[3] = 1'b0;
    drive();
    drain("t5_drain", 50, n);
    check("t5_writes", wr_cnt, 6);

    // Reset while requester 1 is mid-packet
    wr_cnt = 0;
    add_beats(1, 4, 8'hF0, 1'b1, 1'b1);
    drive();
    tick();
    tick();
    tick();
    check("t6_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wr_en", fifo_wr_en, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_grant", grant_id, 0);
    check("t6_rst_data", fifo_wr_data, 0);
    check("t6_rst_pkt_err", pkt_err, 0);
    check("t6_partial_writes", wr_cnt, 2);
    do_reset();
    add_beats(0, 1, 8'h01, 1'b1, 1'b1);
    add_beats(1, 1, 8'h11, 1'b1, 1'b1);
    add_beats(3, 1, 8'h31, 1'b1, 1'b1);
    drive();
    tick();
    check("t6_first_grant", grant_id, 0);
    drain("t6_drain", 50, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
